// File: rtl/rv32i_hazard_scoreboard.sv
// Per-register countdown scoreboard for decode-stage RAW hazard detection.
// Ports:
//   clk_i, resetn_i      : clock and async active-low reset
//   advance_i            : pipeline advances this cycle; 0 freezes all state
//   issue_valid_i        : decode holds a real instruction
//   flush_i              : decode instruction is killed
//   rs1/rs2/rd + flags   : decoded operand info and load flag
//   stall_o              : hold decode, insert bubble into EXE
//   busy_o               : per-register pending-write flags
//   stall_cnt_o          : saturating count of stalled advance cycles
//   fwd_rs1_o/fwd_rs2_o  : forwarding distance (only with HAZARD_FWD_EN)
// Optional feature macro: HAZARD_FWD_EN (forwarding, load-use-only stalls).
module rv32i_hazard_scoreboard #(
  parameter int NB_REGS   = 32,
  parameter int REG_ADD_W = 5,
  parameter int WB_LAT    = 3,
  parameter int CNT_W     = 3,
  parameter int PERF_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 resetn_i,
  input  logic                 advance_i,
  input  logic                 issue_valid_i,
  input  logic                 flush_i,
  input  logic [REG_ADD_W-1:0] rs1_add_i,
  input  logic                 rs1_used_i,
  input  logic [REG_ADD_W-1:0] rs2_add_i,
  input  logic                 rs2_used_i,
  input  logic [REG_ADD_W-1:0] rd_add_i,
  input  logic                 rd_we_i,
  input  logic                 is_load_i,
  output logic                 stall_o,
  output logic [NB_REGS-1:0]   busy_o,
  output logic [PERF_W-1:0]    stall_cnt_o
`ifdef HAZARD_FWD_EN
  ,
  output logic [CNT_W-1:0]     fwd_rs1_o,
  output logic [CNT_W-1:0]     fwd_rs2_o
`endif
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(WB_LAT);

  logic [CNT_W-1:0]  cnt_q [NB_REGS];
  logic [CNT_W-1:0]  cnt_d [NB_REGS];
  logic [NB_REGS-1:0] ld_q, ld_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [CNT_W-1:0] rs1_cnt, rs2_cnt;
  logic rs1_nz, rs2_nz;
  logic haz1, haz2;
  logic issue;
  logic wr_en;

  always_comb begin
    rs1_cnt = cnt_q[rs1_add_i];
    rs2_cnt = cnt_q[rs2_add_i];
    rs1_nz  = rs1_used_i & (rs1_add_i != '0);
    rs2_nz  = rs2_used_i & (rs2_add_i != '0);
`ifdef HAZARD_FWD_EN
    // Only a load directly ahead of its consumer cannot be forwarded.
    haz1 = rs1_nz & ld_q[rs1_add_i] & (rs1_cnt == LAT);
    haz2 = rs2_nz & ld_q[rs2_add_i] & (rs2_cnt == LAT);
    fwd_rs1_o = (rs1_nz & ~haz1) ? rs1_cnt : '0;
    fwd_rs2_o = (rs2_nz & ~haz2) ? rs2_cnt : '0;
`else
    haz1 = rs1_nz & (rs1_cnt != '0);
    haz2 = rs2_nz & (rs2_cnt != '0);
`endif
    stall_o = issue_valid_i & ~flush_i & (haz1 | haz2);
    issue   = advance_i & issue_valid_i & ~flush_i & ~stall_o;
    wr_en   = issue & rd_we_i & (rd_add_i != '0);
  end

`ifndef HAZARD_FWD_EN
  // Load tags are tracked regardless; only forwarding consumes them.
  logic ld_unused;
  assign ld_unused = ^ld_q;
`endif

  always_comb begin
    for (int r = 0; r < NB_REGS; r++) begin
      logic [CNT_W-1:0] dec;
      dec      = (cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
      cnt_d[r] = cnt_q[r];
      ld_d[r]  = ld_q[r];
      busy_o[r] = (cnt_q[r] != '0);
      if (advance_i) begin
        if (wr_en && (rd_add_i == REG_ADD_W'(r))) begin
          // WAW keeps whichever producer retires last.
          cnt_d[r] = (dec > LAT) ? dec : LAT;
          ld_d[r]  = is_load_i;
        end else begin
          cnt_d[r] = dec;
          if (dec == '0) ld_d[r] = 1'b0;
        end
      end
    end
    cnt_d[0] = '0;
    ld_d[0]  = 1'b0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (advance_i && stall_o && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  assign stall_cnt_o = stall_cnt_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int r = 0; r < NB_REGS; r++) cnt_q[r] <= '0;
      ld_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NB_REGS; r++) cnt_q[r] <= cnt_d[r];
      ld_q        <= ld_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_rv32i_hazard_scoreboard.sv
// Self-checking bench for rv32i_hazard_scoreboard.
// Per-cycle expected stall/count pushed to a queue, popped at sample time.
module tb_rv32i_hazard_scoreboard;

  logic clk_i = 1'b0;
  logic resetn_i;
  logic advance_i, issue_valid_i, flush_i;
  logic [4:0] rs1_add_i, rs2_add_i, rd_add_i;
  logic rs1_used_i, rs2_used_i, rd_we_i, is_load_i;
  logic stall_o, s_stall;
  logic [31:0] busy_o, s_busy;
  logic [31:0] stall_cnt_o;
  logic [1:0] s_cnt;
`ifdef HAZARD_FWD_EN
  logic [2:0] fwd_rs1_o, fwd_rs2_o, s_f1, s_f2;
`endif

  rv32i_hazard_scoreboard dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .advance_i(advance_i),
    .issue_valid_i(issue_valid_i), .flush_i(flush_i),
    .rs1_add_i(rs1_add_i), .rs1_used_i(rs1_used_i),
    .rs2_add_i(rs2_add_i), .rs2_used_i(rs2_used_i),
    .rd_add_i(rd_add_i), .rd_we_i(rd_we_i), .is_load_i(is_load_i),
    .stall_o(stall_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
`ifdef HAZARD_FWD_EN
    , .fwd_rs1_o(fwd_rs1_o), .fwd_rs2_o(fwd_rs2_o)
`endif
  );

  // Narrow counter copy to observe saturation.
  rv32i_hazard_scoreboard #(.PERF_W(2)) dut_sat (
    .clk_i(clk_i), .resetn_i(resetn_i), .advance_i(advance_i),
    .issue_valid_i(issue_valid_i), .flush_i(flush_i),
    .rs1_add_i(rs1_add_i), .rs1_used_i(rs1_used_i),
    .rs2_add_i(rs2_add_i), .rs2_used_i(rs2_used_i),
    .rd_add_i(rd_add_i), .rd_we_i(rd_we_i), .is_load_i(is_load_i),
    .stall_o(s_stall), .busy_o(s_busy), .stall_cnt_o(s_cnt)
`ifdef HAZARD_FWD_EN
    , .fwd_rs1_o(s_f1), .fwd_rs2_o(s_f2)
`endif
  );

  always #10 clk_i = ~clk_i;

  typedef struct {
    bit stall;
    int scnt;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int exp_scnt = 0;

  task automatic ins(input bit v, input int rs1, input bit u1,
                     input int rs2, input bit u2, input int rd,
                     input bit we, input bit ld);
    issue_valid_i = v;
    rs1_add_i = 5'(rs1); rs1_used_i = u1;
    rs2_add_i = 5'(rs2); rs2_used_i = u2;
    rd_add_i = 5'(rd); rd_we_i = we; is_load_i = ld;
  endtask

  task automatic idle();
    ins(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called 1 unit after posedge; samples at +5, returns at next posedge+1.
  task automatic cyc(input bit adv, input bit fl, input bit exp_stall,
                     input string nm);
    exp_t e;
    advance_i = adv;
    flush_i = fl;
    q.push_back('{exp_stall, exp_scnt});
    #4;
    e = q.pop_front();
    checks++;
    if (stall_o !== e.stall) begin
      errors++;
      $display("FAIL %s stall_o got %0b exp %0b", nm, stall_o, e.stall);
    end
    checks++;
    if (stall_cnt_o !== 32'(e.scnt)) begin
      errors++;
      $display("FAIL %s stall_cnt got %0d exp %0d", nm, stall_cnt_o, e.scnt);
    end
    if (adv && exp_stall) exp_scnt++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_busy(input int r, input bit exp, input string nm);
    checks++;
    if (busy_o[r] !== exp) begin
      errors++;
      $display("FAIL %s busy[%0d] got %0b exp %0b", nm, r, busy_o[r], exp);
    end
  endtask

  task automatic chk_sat(input int exp, input string nm);
    checks++;
    if (s_cnt !== 2'(exp)) begin
      errors++;
      $display("FAIL %s sat_cnt got %0d exp %0d", nm, s_cnt, exp);
    end
  endtask

  task automatic drain();
    idle();
    repeat (4) cyc(1, 0, 0, "drain");
    checks++;
    if (busy_o !== 32'h0) begin
      errors++;
      $display("FAIL drain busy got %h exp 0", busy_o);
    end
  endtask

  task automatic test_reset();
    resetn_i = 1'b0;
    advance_i = 1'b1;
    flush_i = 1'b0;
    ins(1, 0, 0, 0, 0, 4, 1, 0);
    #2;
    checks++;
    if (busy_o !== 32'h0 || stall_o !== 1'b0 || stall_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL reset got busy=%h stall=%0b cnt=%0d exp 0/0/0",
               busy_o, stall_o, stall_cnt_o);
    end
    @(posedge clk_i);
    #1;
    chk_busy(4, 0, "reset_hold");
    resetn_i = 1'b1;
    idle();
    cyc(1, 0, 0, "reset_rel");
  endtask

  task automatic test_raw();
    ins(1, 0, 0, 0, 0, 5, 1, 0);
    cyc(1, 0, 0, "raw_addi");
    chk_busy(5, 1, "raw_busy5");
    ins(1, 5, 1, 1, 1, 6, 1, 0);
    cyc(1, 0, 1, "raw_st1");
    cyc(1, 0, 1, "raw_st2");
    cyc(1, 0, 1, "raw_st3");
    chk_busy(5, 0, "raw_clr5");
    chk_busy(6, 0, "raw_no6");
    cyc(1, 0, 0, "raw_issue");
    chk_busy(6, 1, "raw_busy6");
    chk_sat(3, "raw_sat");
    drain();
  endtask

  task automatic test_x0();
    ins(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, "x0_wr");
    chk_busy(0, 0, "x0_busy0");
    ins(1, 0, 1, 0, 1, 3, 1, 0);
    cyc(1, 0, 0, "x0_rd");
    chk_busy(3, 1, "x0_busy3");
    chk_busy(0, 0, "x0_busy0b");
    drain();
  endtask

  task automatic test_freeze();
    ins(1, 0, 0, 0, 0, 7, 1, 1);
    cyc(1, 0, 0, "ld_lw");
    ins(1, 7, 1, 7, 1, 8, 1, 0);
    cyc(1, 0, 1, "ld_st1");
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, "ld_frozen");
    chk_busy(7, 1, "ld_busy7");
    cyc(1, 0, 1, "ld_st2");
    cyc(1, 0, 1, "ld_st3");
    cyc(1, 0, 0, "ld_issue");
    checks++;
    if (stall_cnt_o !== 32'd6) begin
      errors++;
      $display("FAIL ld_total got %0d exp 6", stall_cnt_o);
    end
    chk_sat(3, "ld_sat_hold");
    drain();
  endtask

  task automatic test_flush();
    ins(1, 0, 0, 0, 0, 5, 1, 0);
    cyc(1, 0, 0, "fl_prod");
    ins(1, 5, 1, 0, 0, 10, 1, 0);
    cyc(1, 1, 0, "fl_kill");
    chk_busy(10, 0, "fl_noissue");
    cyc(1, 0, 1, "fl_st1");
    cyc(1, 0, 1, "fl_st2");
    cyc(1, 0, 0, "fl_issue");
    chk_busy(10, 1, "fl_busy10");
    drain();
  endtask

  task automatic test_waw_reset();
    ins(1, 0, 0, 0, 0, 9, 1, 1);
    cyc(1, 0, 0, "waw_lw");
    ins(1, 0, 0, 0, 0, 9, 1, 0);
    cyc(1, 0, 0, "waw_alu");
    idle();
    cyc(1, 0, 0, "waw_i1");
    cyc(1, 0, 0, "waw_i2");
    chk_busy(9, 1, "waw_busy9");
    ins(1, 9, 1, 0, 0, 12, 1, 0);
    resetn_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 32'h0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset got busy=%h stall=%0b exp 0/0", busy_o, stall_o);
    end
    checks++;
    if (stall_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL midreset_cnt got %0d exp 0", stall_cnt_o);
    end
    chk_sat(0, "midreset_sat");
    exp_scnt = 0;
    @(posedge clk_i);
    #1;
    resetn_i = 1'b1;
    cyc(1, 0, 0, "post_reset");
    chk_busy(12, 1, "post_busy12");
    drain();
  endtask

`ifdef HAZARD_FWD_EN
  task automatic test_fwd();
    ins(1, 0, 0, 0, 0, 5, 1, 0);
    cyc(1, 0, 0, "fwd_addi");
    ins(1, 5, 1, 0, 0, 6, 1, 0);
    advance_i = 1'b1;
    #2;
    checks++;
    if (fwd_rs1_o !== 3'd3) begin
      errors++;
      $display("FAIL fwd_alu got %0d exp 3", fwd_rs1_o);
    end
    cyc(1, 0, 0, "fwd_alu_nostall");
    ins(1, 0, 0, 0, 0, 7, 1, 1);
    cyc(1, 0, 0, "fwd_lw");
    ins(1, 7, 1, 7, 1, 8, 1, 0);
    cyc(1, 0, 1, "fwd_lu_stall");
    #2;
    checks++;
    if (fwd_rs1_o !== 3'd2 || fwd_rs2_o !== 3'd2) begin
      errors++;
      $display("FAIL fwd_lu got %0d/%0d exp 2/2", fwd_rs1_o, fwd_rs2_o);
    end
    cyc(1, 0, 0, "fwd_lu_issue");
    drain();
  endtask
`endif

  initial begin
    test_reset();
`ifdef HAZARD_FWD_EN
    test_fwd();
`else
    test_raw();
    test_x0();
    test_freeze();
    test_flush();
    test_waw_reset();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_hazard_scoreboard.md
Name: rv32i_hazard_scoreboard

Overview:
Parametrised register-hazard scoreboard for the RV32I pipeline control path.
- Replaces opcode-comparison RAW detection with a per-register countdown scoreboard.
- Supports any pipeline writeback distance and tracks load producers separately.
- Provides a saturating stall-cycle performance counter and optional forwarding-select generation.
- Sits in the decode stage: it is fed by the decoder and drives the stall/bubble logic of the control path.

Parameters:
NB_REGS, 32, number of architectural registers; register 0 is hard-wired zero and never pending.
REG_ADD_W, 5, register address width; must equal $clog2(NB_REGS).
WB_LAT, 3, advances from issue until the result is readable from the register file; legal range 1..(2**CNT_W - 1).
CNT_W, 3, width of each per-register countdown counter.
PERF_W, 32, width of the stall-cycle counter.

Ports:
clk_i  input  1  clock, rising edge
resetn_i  input  1  asynchronous active-low reset
advance_i  input  1  pipeline advances this cycle (imem valid); when 0 the scoreboard freezes
issue_valid_i  input  1  decode holds a real instruction
flush_i  input  1  branch taken; the decode instruction is killed
rs1_add_i  input  REG_ADD_W  source 1 address
rs1_used_i  input  1  instruction reads rs1
rs2_add_i  input  REG_ADD_W  source 2 address
rs2_used_i  input  1  instruction reads rs2
rd_add_i  input  REG_ADD_W  destination address
rd_we_i  input  1  instruction writes rd
is_load_i  input  1  instruction is a load
stall_o  output  1  hold decode and insert a bubble into EXE
busy_o  output  NB_REGS  bit r set when cnt[r] != 0
stall_cnt_o  output  PERF_W  saturating count of stalled advance cycles
fwd_rs1_o  output  CNT_W  forwarding distance for rs1 (present only with HAZARD_FWD_EN)
fwd_rs2_o  output  CNT_W  forwarding distance for rs2 (present only with HAZARD_FWD_EN)

Behaviour:
- State:
  - cnt[r] (CNT_W bits) for each register.
  - ld[r] (1 bit) for each register, set when the pending producer of r is a load.
  - stall counter.
- Reset (async, resetn_i=0):
  - All cnt = 0, all ld = 0, stall_cnt_o = 0.
  - busy_o = 0 and fwd outputs = 0; stall_o = 0.
- Hazard, without forwarding:
  - hazX = rsX_used_i & (rsX_add_i != 0) & (cnt[rsX_add_i] != 0).
  - stall_o = issue_valid_i & ~flush_i & (haz1 | haz2). Combinational; uses pre-update counters.
- An instruction's own rd never stalls itself: rs1 == rd with no prior pending write gives no stall.
- Issue = advance_i & issue_valid_i & ~flush_i & ~stall_o.
- Per-register update, on each cycle with advance_i=1:
  - If issue & rd_we_i & rd != 0 for this register: cnt <= max(cnt-1 saturating at 0, WB_LAT) and ld <= is_load_i. Write-after-write takes the longer remaining latency.
  - Otherwise: if cnt != 0 then cnt <= cnt-1; when cnt reaches 0, ld <= 0.
- advance_i=0: all counters, ld bits and the stall counter hold. stall_o still evaluates combinationally.
- flush_i=1: no issue and stall_o=0. Counters of older in-flight instructions keep decrementing, because they still retire.
- Stall counter: increments when advance_i & stall_o; saturates at all-ones with no wrap.
- Latency: a dependent instruction issues on the advance where the producer's cnt is 0. With WB_LAT=3 this means exactly 3 bubbles for back-to-back RAW.
- Reset asserted mid-operation clears all pending state immediately. No stall persists after release.

Optional Feature:
HAZARD_FWD_EN
- Defined:
  - hazX = rsX_used_i & (rsX_add_i != 0) & ld[rsX_add_i] & (cnt[rsX_add_i] == WB_LAT). Only a load-use immediately behind its load stalls, for one bubble.
  - fwd_rsX_o = cnt[rsX_add_i] when rsX_used_i & rsX_add_i != 0 & ~hazX, else 0.
  - Encoding: 0 = register file, k = producer is k advances from writeback; the datapath muxes the matching stage result.
- Undefined: fwd ports are absent and stall behaviour is as above.

Test Plan:
- Reset → busy_o=0, stall_o=0, stall_cnt_o=0. Issue `addi x5` then `add x6,x5,x1` back-to-back with advance_i=1 → stall_o=1 for 3 cycles, stall_cnt_o=3, issue on 4th cycle, busy_o[5] clears after it.
- Issue `addi x0,…` then a reader of x0 → never stalls; busy_o[0] stays 0.
- Issue `lw x7` followed by `add x8,x7,x7` → stall asserted. Drop advance_i for 5 cycles mid-stall → cnt[7] and stall_cnt_o frozen; total stall_cnt_o=3 after resume.
- A dependent reader of x5 in decode with flush_i=1 → stall_o=0, no issue, cnt[5] still decrements.
- Load x9 (cnt 3) then ALU x9 on the next advance → cnt[9]=max(2,3)=3 and ld[9]=0. Assert resetn_i low mid-sequence → all busy bits 0 immediately.
- With HAZARD_FWD_EN: `addi x5` then a reader of x5 → no stall, fwd_rs1_o=3. `lw x7` then a reader → 1 stall, then fwd=2.
